// File: rtl/dll_request_scheduler.sv
// Initiator side of the channel-to-DLL interface: queues early/late IQ requests, issues them
// to the shared DLL paced to its sampling period, and writes back saturated code phase increments.
module dll_request_scheduler #(
    parameter int CHANNEL_ID_WIDTH = 4,
    parameter int IQ_WIDTH         = 16,
    parameter int DPHI_WIDTH       = 16,
    parameter int INC_WIDTH        = 24,
    parameter int FIFO_DEPTH       = 4,
    parameter int ISSUE_HOLD       = 8,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic [CHANNEL_ID_WIDTH-1:0] req_tag,
    input  logic [IQ_WIDTH-1:0]         req_iq_early,
    input  logic [IQ_WIDTH-1:0]         req_iq_late,
    output logic                        req_ready,
    output logic                        dll_start,
    output logic [CHANNEL_ID_WIDTH-1:0] dll_tag,
    output logic [IQ_WIDTH-1:0]         dll_iq_early,
    output logic [IQ_WIDTH-1:0]         dll_iq_late,
    input  logic                        dll_result_ready,
    input  logic [CHANNEL_ID_WIDTH-1:0] dll_result_tag,
    input  logic [DPHI_WIDTH-1:0]       dll_delta_phase_increment,
    input  logic [INC_WIDTH-1:0]        nominal_inc,
    output logic                        inc_wr_en,
    output logic [CHANNEL_ID_WIDTH-1:0] inc_wr_tag,
    output logic [INC_WIDTH-1:0]        inc_wr_value,
    output logic [1:0]                  outstanding,
    output logic                        err_overflow,
    output logic                        err_spurious
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int HOLD_W = $clog2(ISSUE_HOLD + 1);
    localparam int SUM_W  = INC_WIDTH + 2;

    localparam logic [CNT_W-1:0]     DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(ISSUE_HOLD - 1);
    localparam logic [1:0]           MAX_OUT   = 2'(MAX_OUTSTANDING);
    localparam logic [INC_WIDTH-1:0] INC_MAX   = '1;

    typedef struct packed {
        logic [CHANNEL_ID_WIDTH-1:0] tag;
        logic [IQ_WIDTH-1:0]         early;
        logic [IQ_WIDTH-1:0]         late;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    req_t              mem [FIFO_DEPTH];
    req_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic              launch;

    logic              result_ok;
    logic [SUM_W-1:0]  sum;
    logic [INC_WIDTH-1:0] sat_value;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign req_ready = !full && !reset;
    assign push      = req_valid && req_ready;
    assign pop       = (state == ISSUE);
    assign head      = mem[rd_ptr];
    assign result_ok = dll_result_ready && (outstanding != 2'd0);

    // NOTE: the queue storage has no reset; the occupancy count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_tag, req_iq_early, req_iq_late};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (req_valid && full) err_overflow <= 1'b1;
        end
    end

    // NOTE: next state is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!empty && (outstanding < MAX_OUT)) state_next = ISSUE;
            ISSUE:   state_next = HOLD;
            HOLD:    if (hold_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign launch = (state == IDLE) && (state_next == ISSUE);

    // Issue outputs are registered on the way into ISSUE, then frozen through HOLD and IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            dll_start    <= 1'b0;
            dll_tag      <= '0;
            dll_iq_early <= '0;
            dll_iq_late  <= '0;
        end else begin
            state     <= state_next;
            dll_start <= launch;
            if (state == ISSUE) begin
                hold_cnt <= HOLD_LAST;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            if (launch) begin
                dll_tag      <= head.tag;
                dll_iq_early <= head.early;
                dll_iq_late  <= head.late;
            end
        end
    end

    // Two guard bits catch both underflow below zero and overflow past the increment range.
    assign sum = {2'b00, nominal_inc}
               + {{(SUM_W - DPHI_WIDTH){dll_delta_phase_increment[DPHI_WIDTH-1]}}, dll_delta_phase_increment};

    always_comb begin
        sat_value = sum[INC_WIDTH-1:0];
        if (sum[SUM_W-1]) begin
            sat_value = '0;
        end else if (sum[INC_WIDTH]) begin
            sat_value = INC_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding  <= 2'd0;
            inc_wr_en    <= 1'b0;
            inc_wr_tag   <= '0;
            inc_wr_value <= '0;
            err_spurious <= 1'b0;
        end else begin
            case ({pop, result_ok})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
            inc_wr_en <= result_ok;
            if (result_ok) begin
                inc_wr_tag   <= dll_result_tag;
                inc_wr_value <= sat_value;
            end
            if (dll_result_ready && (outstanding == 2'd0)) err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dll_request_scheduler.sv
// Self-checking bench: queue/pacing/write-back model compared every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_dll_request_scheduler;

    localparam int TW    = 4;
    localparam int IW    = 16;
    localparam int DW    = 16;
    localparam int NW    = 24;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int MAXO  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid;
    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_iq_early;
    logic [IW-1:0] req_iq_late;
    logic          req_ready;
    logic          dll_start;
    logic [TW-1:0] dll_tag;
    logic [IW-1:0] dll_iq_early;
    logic [IW-1:0] dll_iq_late;
    logic          dll_result_ready;
    logic [TW-1:0] dll_result_tag;
    logic [DW-1:0] dll_delta_phase_increment;
    logic [NW-1:0] nominal_inc;
    logic          inc_wr_en;
    logic [TW-1:0] inc_wr_tag;
    logic [NW-1:0] inc_wr_value;
    logic [1:0]    outstanding;
    logic          err_overflow;
    logic          err_spurious;

    dll_request_scheduler #(
        .CHANNEL_ID_WIDTH(TW), .IQ_WIDTH(IW), .DPHI_WIDTH(DW), .INC_WIDTH(NW),
        .FIFO_DEPTH(DEPTH), .ISSUE_HOLD(HOLD), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_tag(req_tag), .req_iq_early(req_iq_early),
        .req_iq_late(req_iq_late), .req_ready(req_ready),
        .dll_start(dll_start), .dll_tag(dll_tag), .dll_iq_early(dll_iq_early),
        .dll_iq_late(dll_iq_late),
        .dll_result_ready(dll_result_ready), .dll_result_tag(dll_result_tag),
        .dll_delta_phase_increment(dll_delta_phase_increment), .nominal_inc(nominal_inc),
        .inc_wr_en(inc_wr_en), .inc_wr_tag(inc_wr_tag), .inc_wr_value(inc_wr_value),
        .outstanding(outstanding), .err_overflow(err_overflow), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [TW-1:0] tag;
        logic [IW-1:0] early;
        logic [IW-1:0] late;
    } req_t;

    req_t          mq[$];
    req_t          m_dll;
    int            m_out;
    bit            m_start;
    bit            m_wr;
    logic [TW-1:0] m_wr_tag;
    logic [NW-1:0] m_wr_val;
    bit            m_ovf;
    bit            m_spur;
    longint        cyc;
    longint        last_start;
    logic [TW-1:0] started[$];
    int            wr_count;

    function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] nom, input logic [DW-1:0] d);
        longint s;
        logic [63:0] u;
        s = longint'(nom) + longint'($signed(d));
        if (s < 0) return '0;
        if (s > (longint'(1) << NW) - 1) return '1;
        u = s;
        return u[NW-1:0];
    endfunction

    // Each posedge: derive what the outputs must be for the coming cycle, then compare at +1.
    initial begin
        bit     ready;
        bit     go;
        bit     dec;
        longint n;
        cyc        = 0;
        last_start = -1000;
        wr_count   = 0;
        forever begin
            @(posedge clk);
            n = cyc;
            cyc++;
            if (reset) begin
                mq.delete();
                m_dll      = '{default: '0};
                m_out      = 0;
                m_start    = 0;
                m_wr       = 0;
                m_wr_tag   = '0;
                m_wr_val   = '0;
                m_ovf      = 0;
                m_spur     = 0;
                last_start = -1000;
            end else begin
                ready = (mq.size() < DEPTH);
                go    = (mq.size() > 0) && (m_out < MAXO) && (n - last_start >= HOLD + 1);
                dec   = dll_result_ready && (m_out > 0);
                if (dll_result_ready && m_out == 0) m_spur = 1;
                if (req_valid && !ready) m_ovf = 1;
                m_wr = dec;
                if (dec) begin
                    m_wr_tag = dll_result_tag;
                    m_wr_val = sat_inc(nominal_inc, dll_delta_phase_increment);
                end
                if (go) begin
                    m_dll      = mq[0];
                    last_start = n + 1;
                end
                if (m_start) begin
                    void'(mq.pop_front());
                    m_out++;
                end
                if (dec) m_out--;
                m_start = go;
                if (req_valid && ready) mq.push_back('{req_tag, req_iq_early, req_iq_late});
            end
            #1;
            check("dll_start", dll_start, m_start);
            check("dll_tag", dll_tag, m_dll.tag);
            check("dll_iq_early", dll_iq_early, m_dll.early);
            check("dll_iq_late", dll_iq_late, m_dll.late);
            check("outstanding", outstanding, m_out);
            check("inc_wr_en", inc_wr_en, m_wr);
            if (m_wr) begin
                check("inc_wr_tag", inc_wr_tag, m_wr_tag);
                check("inc_wr_value", inc_wr_value, m_wr_val);
            end
            check("err_overflow", err_overflow, m_ovf);
            check("err_spurious", err_spurious, m_spur);
            check("req_ready", req_ready, !reset && (mq.size() < DEPTH));
            if (dll_start) started.push_back(dll_tag);
            if (inc_wr_en) wr_count++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [TW-1:0] t, input logic [IW-1:0] e, input logic [IW-1:0] l);
        req_valid    = 1'b1;
        req_tag      = t;
        req_iq_early = e;
        req_iq_late  = l;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    task automatic send_result(input logic [TW-1:0] t, input logic [DW-1:0] d);
        dll_result_ready          = 1'b1;
        dll_result_tag            = t;
        dll_delta_phase_increment = d;
        @(negedge clk);
        dll_result_ready          = 1'b0;
    endtask

    task automatic wait_starts(input int n, input string name);
        int i = 0;
        while (started.size() < n && i < 60) begin
            @(negedge clk);
            i++;
        end
        check({name, " start seen"}, started.size() >= n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        req_valid                 = 1'b0;
        req_tag                   = '0;
        req_iq_early              = '0;
        req_iq_late               = '0;
        dll_result_ready          = 1'b0;
        dll_result_tag            = '0;
        dll_delta_phase_increment = '0;
        nominal_inc               = 24'h100000;

        repeat (3) @(negedge clk);
        check("rst dll_start", dll_start, 0);
        check("rst outstanding", outstanding, 0);
        check("rst req_ready", req_ready, 0);
        check("rst inc_wr_en", inc_wr_en, 0);
        reset = 1'b0;

        // Single request, result +5 on nominal 0x100000
        started.delete();
        push(4'd3, 16'd1000, 16'd900);
        wait_starts(1, "t1");
        check("t1 tag", dll_tag, 3);
        check("t1 early", dll_iq_early, 1000);
        check("t1 late", dll_iq_late, 900);
        tick();
        check("t1 outstanding", outstanding, 1);
        send_result(4'd3, 16'd5);
        check("t1 wr_en", inc_wr_en, 1);
        check("t1 wr_tag", inc_wr_tag, 3);
        check("t1 wr_value", inc_wr_value, 24'h100005);
        check("t1 outstanding after", outstanding, 0);
        check("t1 tag held", dll_tag, 3);
        repeat (12) tick();

        // Six back-to-back pushes into a depth-4 queue: one pop frees a slot, the sixth drops
        started.delete();
        for (int k = 1; k <= 6; k++) push(TW'(k), IW'(k * 100), IW'(k * 10));
        check("t2 overflow", err_overflow, 1);
        for (int k = 0; k < 5; k++) begin
            wait_starts(k + 1, "t2");
            tick();
            send_result(started[k], 16'd0);
        end
        repeat (30) tick();
        check("t2 start count", started.size(), 5);
        for (int k = 0; k < 5; k++) check("t2 order", started[k], k + 1);

        // Outstanding limit: three queued, no results -> two issues only
        started.delete();
        push(4'd7, 16'd70, 16'd7);
        push(4'd8, 16'd80, 16'd8);
        push(4'd9, 16'd90, 16'd9);
        repeat (40) tick();
        check("t3 two starts", started.size(), 2);
        check("t3 outstanding", outstanding, 2);
        send_result(4'd7, 16'd0);
        if (started.size() < 3) tick();
        check("t3 third start", started.size(), 3);
        check("t3 third tag", started[2], 9);
        tick();
        dll_result_ready          = 1'b1;
        dll_result_tag            = 4'd8;
        dll_delta_phase_increment = 16'd3;
        tick();
        check("t3 b2b wr1 en", inc_wr_en, 1);
        check("t3 b2b wr1 tag", inc_wr_tag, 8);
        dll_result_tag = 4'd9;
        tick();
        dll_result_ready = 1'b0;
        check("t3 b2b wr2 en", inc_wr_en, 1);
        check("t3 b2b wr2 tag", inc_wr_tag, 9);
        check("t3 b2b wr2 value", inc_wr_value, 24'h100003);
        tick();
        check("t3 drained", outstanding, 0);

        // Saturation at both ends
        started.delete();
        push(4'd4, 16'd1, 16'd2);
        wait_starts(1, "t4a");
        tick();
        nominal_inc = 24'd3;
        send_result(4'd4, 16'hFFF6);
        check("t4 low wr_en", inc_wr_en, 1);
        check("t4 low sat", inc_wr_value, 0);
        push(4'd5, 16'd3, 16'd4);
        wait_starts(2, "t4b");
        tick();
        nominal_inc = 24'hFFFFF0;
        send_result(4'd5, 16'h7FFF);
        check("t4 high sat", inc_wr_value, 24'hFFFFFF);
        nominal_inc = 24'h100000;

        // Spurious result, then a result landing on an ISSUE cycle
        send_result(4'd6, 16'd0);
        check("t5 spurious no write", inc_wr_en, 0);
        check("t5 err_spurious", err_spurious, 1);
        check("t5 outstanding zero", outstanding, 0);
        started.delete();
        push(4'd12, 16'd12, 16'd12);
        wait_starts(1, "t5a");
        tick();
        push(4'd13, 16'd13, 16'd13);
        wait_starts(2, "t5b");
        check("t5 in issue", dll_start, 1);
        send_result(4'd12, 16'd0);
        check("t5 coincident outstanding", outstanding, 1);
        tick();
        send_result(4'd13, 16'd0);
        check("t5 final outstanding", outstanding, 0);
        repeat (12) tick();

        // Reset during HOLD abandons the issued request
        started.delete();
        push(4'd10, 16'd111, 16'd222);
        wait_starts(1, "t6a");
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t6 dll_start", dll_start, 0);
        check("t6 dll_tag", dll_tag, 0);
        check("t6 dll_early", dll_iq_early, 0);
        check("t6 dll_late", dll_iq_late, 0);
        check("t6 outstanding", outstanding, 0);
        check("t6 err_overflow", err_overflow, 0);
        check("t6 err_spurious", err_spurious, 0);
        check("t6 inc_wr_en", inc_wr_en, 0);
        check("t6 inc_wr_value", inc_wr_value, 0);
        check("t6 req_ready", req_ready, 0);
        tick();
        reset = 1'b0;
        wr_count = 0;
        started.delete();
        push(4'd11, 16'd333, 16'd444);
        wait_starts(1, "t6b");
        check("t6 new tag", started[0], 11);
        check("t6 new early", dll_iq_early, 333);
        check("t6 new late", dll_iq_late, 444);
        repeat (20) tick();
        check("t6 no stale write", wr_count, 0);
        send_result(4'd11, 16'hFFFF);
        check("t6 write value", inc_wr_value, 24'h0FFFFF);
        check("t6 write tag", inc_wr_tag, 11);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
